// File: rtl/dfp_sig_mul_seq_pkg.sv
// Shared DFP definitions: significand digit counts, BCD digit type and the
// sequencer state encoding for the significand multiplier.
package dfp_sig_mul_seq_pkg;

    localparam int DFP128_DIGITS = 34;
    localparam int DFP64_DIGITS  = 16;
    localparam int DFP32_DIGITS  = 7;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic digit_valid(input bcd_digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/dfp_sig_mul_seq_if.sv
// Operand/result bundle of the BCD significand multiplier.
interface dfp_sig_mul_seq_if #(
    parameter int N = 34
) ();
    logic             ce;
    logic             ld;
    logic [4*N-1:0]   a;
    logic [4*N-1:0]   b;
    logic [8*N-1:0]   p;
    logic             done;
    logic             inv;

    modport master (output ce, ld, a, b, input  p, done, inv);
    modport slave  (input  ce, ld, a, b, output p, done, inv);
endinterface

// File: rtl/dfp_sig_mul_seq_bcd_add_n.sv
// Ripple-carry D-digit packed-BCD adder with decimal carry-in and carry-out.
module bcd_add_n #(
    parameter int D = 35
) (
    input  logic [4*D-1:0] x_i,
    input  logic [4*D-1:0] y_i,
    input  logic           c_i,
    output logic [4*D-1:0] s_o,
    output logic           c_o
);
    logic [D:0] carry;

    assign carry[0] = c_i;

    for (genvar gi = 0; gi < D; gi++) begin : g_dig
        logic [4:0] raw;
        assign raw = {1'b0, x_i[4*gi +: 4]} + {1'b0, y_i[4*gi +: 4]} + {4'd0, carry[gi]};
        // Binary sums 10..19 are folded back into a decimal digit by adding 6.
        assign carry[gi+1]     = raw > 5'd9;
        assign s_o[4*gi +: 4]  = carry[gi+1] ? raw[3:0] + 4'd6 : raw[3:0];
    end

    assign c_o = carry[D];
endmodule

// File: rtl/dfp_sig_mul_seq.sv
// Multi-cycle N-digit BCD significand multiplier: repeated-add per multiplier
// digit with a one-digit right shift between digits, optional early finish.
module dfp_sig_mul_seq
    import dfp_sig_mul_seq_pkg::*;
#(
    parameter int N     = DFP128_DIGITS,
    parameter bit EARLY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    dfp_sig_mul_seq_if.slave    bus_if
);
    localparam int             AW      = 4*(2*N+1);
    localparam int             CW      = $clog2(N+1);
    localparam logic [CW-1:0]  N_C     = CW'(N);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [4*N-1:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        dig_q, dig_d;
    logic [8*N-1:0]    p_q, p_d;
    logic              done_q, done_d;
    logic              inv_q, inv_d;

    logic [2*N-1:0]    nib_bad;
    logic [N-1:0]      b_nz;
    logic [CW-1:0]     cnt_inc;
    logic              hi_zero;
    logic [CW+1:0]     early_shamt;
    logic [AW-1:0]     acc_shr1, acc_early;
    logic [4*N-1:0]    b_shr;
    logic [4*(N+1)-1:0] add_sum;
    logic              add_co;

    for (genvar gi = 0; gi < N; gi++) begin : g_nib
        assign nib_bad[gi]   = !digit_valid(bus_if.a[4*gi +: 4]);
        assign nib_bad[N+gi] = !digit_valid(bus_if.b[4*gi +: 4]);
        assign b_nz[gi]      = |b_q[4*gi +: 4];
    end

    assign cnt_inc     = cnt_q + CNT_ONE;
    assign hi_zero     = (b_nz >> cnt_inc) == '0;
    assign early_shamt = {N_C - cnt_q, 2'b00};
    assign acc_shr1    = acc_q >> 4;
    assign acc_early   = acc_q >> early_shamt;
    assign b_shr       = b_q >> {cnt_inc, 2'b00};

    // The multiplicand is always added at digit N; the shifts align later digits.
    bcd_add_n #(.D(N+1)) u_add (
        .x_i (acc_q[AW-1 -: 4*(N+1)]),
        .y_i ({4'd0, a_q}),
        .c_i (1'b0),
        .s_o (add_sum),
        .c_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        p_d     = p_q;
        done_d  = done_q;
        inv_d   = inv_q;

        case (state_q)
            ST_MUL: begin
                if (dig_q != 4'd0) begin
                    acc_d = {add_sum, acc_q[4*N-1:0]};
                    dig_d = dig_q - 4'd1;
                end else if (EARLY && hi_zero) begin
                    acc_d   = acc_early;
                    p_d     = acc_early[8*N-1:0];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    acc_d = acc_shr1;
                    cnt_d = cnt_inc;
                    dig_d = b_shr[3:0];
                    if (cnt_inc == N_C) begin
                        p_d     = acc_shr1[8*N-1:0];
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: ;
        endcase

        // A load restarts from scratch regardless of what the sequencer was doing.
        if (bus_if.ld) begin
            a_d    = bus_if.a;
            b_d    = bus_if.b;
            acc_d  = '0;
            cnt_d  = '0;
            dig_d  = bus_if.b[3:0];
            p_d    = '0;
            inv_d  = |nib_bad;
            done_d = |nib_bad;
            state_d = (|nib_bad) ? ST_DONE : ST_MUL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else if (bus_if.ce) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            p_q     <= p_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus_if.ce && state_q == ST_MUL && dig_q != 4'd0)
            assert (!add_co);
        if (!rst && state_q == ST_DONE)
            assert (acc_q[AW-1 -: 4] == 4'd0);
    end

    assign bus_if.p    = p_q;
    assign bus_if.done = done_q;
    assign bus_if.inv  = inv_q;
endmodule

// File: tb/tb_dfp_sig_mul_seq.sv
// Scoreboard bench: a 34-digit fixed-walk instance and a 16-digit early-exit
// instance share stimulus; a decimal reference model predicts product and latency.
module tb_dfp_sig_mul_seq;
    import dfp_sig_mul_seq_pkg::*;

    localparam int NA = DFP128_DIGITS;
    localparam int NB = DFP64_DIGITS;

    typedef struct {
        logic [8*NA-1:0] p;
        logic            inv;
        int              lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, ce, ld;
    logic [4*NA-1:0]  a_v, b_v;

    always #5 clk = ~clk;

    dfp_sig_mul_seq_if #(.N(NA)) if0 ();
    dfp_sig_mul_seq_if #(.N(NB)) if1 ();

    assign if0.ce = ce;
    assign if0.ld = ld;
    assign if0.a  = a_v;
    assign if0.b  = b_v;
    assign if1.ce = ce;
    assign if1.ld = ld;
    assign if1.a  = a_v[4*NB-1:0];
    assign if1.b  = b_v[4*NB-1:0];

    dfp_sig_mul_seq #(.N(NA), .EARLY(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus_if(if0));
    dfp_sig_mul_seq #(.N(NB), .EARLY(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus_if(if1));

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   lat_cnt = 0;
    logic ld_edge = 1'b0;
    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;

    function automatic exp_t model(input logic [4*NA-1:0] a, input logic [4*NA-1:0] b,
                                   input int n, input bit early);
        exp_t e;
        int ad[NA];
        int bd[NA];
        int pd[2*NA+1];
        int sum, k;
        bit bad;
        bad = 0; sum = 0; k = -1;
        for (int i = 0; i < NA; i++) begin
            ad[i] = (i < n) ? int'(a[4*i +: 4]) : 0;
            bd[i] = (i < n) ? int'(b[4*i +: 4]) : 0;
            if (ad[i] > 9 || bd[i] > 9) bad = 1;
        end
        for (int i = 0; i < 2*NA+1; i++) pd[i] = 0;
        e.p = '0;
        e.inv = bad;
        e.lat = 0;
        if (!bad) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    pd[i+j] += ad[i] * bd[j];
            for (int i = 0; i < 2*n; i++) begin
                pd[i+1] += pd[i] / 10;
                pd[i]    = pd[i] % 10;
                e.p[4*i +: 4] = 4'(pd[i]);
            end
            for (int i = 0; i < n; i++) begin
                sum += bd[i];
                if (bd[i] != 0) k = i;
            end
            if (!early)      e.lat = sum + n;
            else if (k < 0)  e.lat = 1;
            else             e.lat = sum + k + 1;
        end
        return e;
    endfunction

    function automatic logic [4*NA-1:0] rand_bcd(input int len, input bit bad);
        logic [4*NA-1:0] v;
        int pos;
        v = '0;
        for (int i = 0; i < len; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (bad) begin
            pos = $urandom_range(0, NA-1);
            v[4*pos +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [8*NA-1:0] got, input logic [8*NA-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check_done(input int id, input logic [8*NA-1:0] got_p, input logic got_inv);
        exp_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("[TB] FAIL dut%0d unexpected_done: got done=1 want no done (p=%h)", id, got_p);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            $display("[TB] dut%0d done p=%h inv=%0d lat=%0d", id, got_p, got_inv, lat_cnt);
            chk($sformatf("dut%0d_p", id), got_p, e.p);
            chk_bit($sformatf("dut%0d_inv", id), got_inv, e.inv);
            tests++;
            if (lat_cnt != e.lat) begin
                fails++;
                $display("[TB] FAIL dut%0d_latency: got %0d want %0d", id, lat_cnt, e.lat);
            end
        end
    endtask

    always @(posedge clk) begin
        ld_edge <= ld && ce && !rst;
        if (rst)            lat_cnt <= 0;
        else if (ld && ce)  lat_cnt <= 0;
        else                lat_cnt <= lat_cnt + 1;
    end

    always @(negedge clk) begin
        if (if0.done && (!done0_prev || ld_edge)) check_done(0, if0.p, if0.inv);
        if (if1.done && (!done1_prev || ld_edge)) check_done(1, 272'(if1.p), if1.inv);
        done0_prev = if0.done;
        done1_prev = if1.done;
    end

    // gap >= 0: another load follows gap edges later, so only faster results are expected.
    task automatic start_op(input logic [4*NA-1:0] a, input logic [4*NA-1:0] b,
                            input int extra, input int gap);
        exp_t e0, e1;
        e0 = model(a, b, NA, 1'b0);
        e1 = model(a, b, NB, 1'b1);
        e0.lat += extra;
        e1.lat += extra;
        if (gap < 0 || e0.lat < gap) q0.push_back(e0);
        if (gap < 0 || e1.lat < gap) q1.push_back(e1);
        @(negedge clk);
        a_v = a;
        b_v = b;
        ld  = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: got %0d/%0d results pending want 0 after %0d cycles",
                     q0.size(), q1.size(), budget);
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [4*NA-1:0] nines, big_a, big_b;
        rst = 1'b1; ce = 1'b1; ld = 1'b0; a_v = '0; b_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_p0", if0.p, '0);
        chk("rst_p1", 272'(if1.p), '0);
        chk_bit("rst_done0", if0.done, 1'b0);
        chk_bit("rst_done1", if1.done, 1'b0);
        chk_bit("rst_inv0", if0.inv, 1'b0);
        chk_bit("rst_inv1", if1.inv, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        start_op(136'h7, 136'h2, 0, -1);
        wait_done(600);

        nines = '0;
        for (int i = 0; i < NB; i++) nines[4*i +: 4] = 4'd9;
        start_op(nines, nines, 0, -1);
        wait_done(600);

        start_op(136'hA, 136'h3, 0, -1);
        wait_done(600);
        big_a = '0;
        big_a[4*20 +: 4] = 4'hF;
        start_op(big_a, 136'h5, 0, -1);
        wait_done(600);

        // Loads while ce is low must be ignored and the held result must persist.
        ce = 1'b0;
        a_v = 136'h4; b_v = 136'h4; ld = 1'b1;
        repeat (3) @(negedge clk);
        ld = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        chk_bit("ce_hold_done0", if0.done, 1'b1);
        chk_bit("ce_hold_done1", if1.done, 1'b1);
        chk_bit("ce_hold_inv0", if0.inv, 1'b1);

        start_op(136'h11, 136'h11, 0, 5);
        repeat (3) @(negedge clk);
        start_op(136'h3, 136'h3, 0, -1);
        wait_done(600);

        big_b = 136'h987654321;
        start_op(136'h123, big_b, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_bit("midrst_done0", if0.done, 1'b0);
        chk_bit("midrst_done1", if1.done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_p0", if0.p, '0);
        start_op(136'h5, 136'h5, 0, -1);
        wait_done(600);

        start_op(136'h123, big_b, 10, -1);
        repeat (5) @(negedge clk);
        ce = 1'b0;
        repeat (10) @(negedge clk);
        ce = 1'b1;
        wait_done(600);

        for (int t = 0; t < 20; t++) begin
            big_a = rand_bcd(NA, ($urandom_range(0, 7) == 0));
            big_b = rand_bcd($urandom_range(0, NA), ($urandom_range(0, 7) == 0));
            start_op(big_a, big_b, 0, -1);
            wait_done(600);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL global_timeout: got still running want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
